// File: rtl/spi_tx_engine.sv
// SPI master transmit/receive engine: mode 0, MSB first, fed by a TX FIFO and feeding an RX FIFO.
// Optional macro SPI_TX_ENGINE_LOOPBACK_EN routes spi_sdo back into the receive sampler internally.
module spi_tx_engine #(
    parameter int CFG_FRAME_SIZE = 8,
    parameter int CFG_CLK_DIV    = 2
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      enable,
    input  logic [CFG_FRAME_SIZE-1:0] tx_data_in,
    input  logic                      tx_flag_in,
    input  logic                      tx_empty_in,
    output logic                      tx_read_out,
    output logic [CFG_FRAME_SIZE-1:0] rx_data_out,
    output logic                      rx_write_out,
    input  logic                      rx_full_in,
    output logic                      rx_overflow_out,
    output logic                      spi_sck,
    output logic                      spi_ssel_n,
    output logic                      spi_sdo,
    input  logic                      spi_sdi,
    output logic                      busy_out,
    output logic                      tx_underrun_out
);
    localparam int BIT_W = $clog2(CFG_FRAME_SIZE);
    localparam int DIV_W = (CFG_CLK_DIV > 1) ? $clog2(CFG_CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_FRAME_SIZE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CFG_CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t                    r_state;
    logic [CFG_FRAME_SIZE-1:0] r_tx;
    logic [CFG_FRAME_SIZE-1:0] r_rx;
    logic                      r_flag;
    logic                      r_sck;
    logic                      r_ssel_n;
    logic [BIT_W-1:0]          r_bit_cnt;
    logic [DIV_W-1:0]          r_div_cnt;

    logic w_start;
    logic w_div_last;
    logic w_frame_end;
    logic w_chain;
    logic w_rx_bit;

`ifdef SPI_TX_ENGINE_LOOPBACK_EN
    assign w_rx_bit = spi_sdo;
`else
    assign w_rx_bit = spi_sdi;
`endif

    // Pop strobes are combinational so the FIFO word is consumed in the same cycle it is captured.
    assign w_start     = (r_state == IDLE) & enable & ~tx_empty_in & ~preset;
    assign w_div_last  = (r_div_cnt == DIV_LAST);
    assign w_frame_end = (r_state == SHIFT) & r_sck & w_div_last & (r_bit_cnt == BIT_LAST);
    assign w_chain     = w_frame_end & ~r_flag & enable & ~tx_empty_in;

    assign tx_read_out     = w_start | w_chain;
    assign rx_write_out    = w_frame_end;
    assign rx_overflow_out = w_frame_end & rx_full_in;
    assign tx_underrun_out = w_frame_end & ~r_flag & enable & tx_empty_in;
    assign rx_data_out     = r_rx;
    assign spi_sck         = r_sck;
    assign spi_ssel_n      = r_ssel_n;
    assign spi_sdo         = (r_state == SHIFT) ? r_tx[CFG_FRAME_SIZE-1] : 1'b0;
    assign busy_out        = (r_state != IDLE);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_flag    <= 1'b0;
            r_sck     <= 1'b0;
            r_ssel_n  <= 1'b1;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sck     <= 1'b0;
                    r_ssel_n  <= 1'b1;
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                    if (w_start) begin
                        r_tx     <= tx_data_in;
                        r_flag   <= tx_flag_in;
                        r_ssel_n <= 1'b0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!w_div_last) begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end else begin
                        r_div_cnt <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[CFG_FRAME_SIZE-2:0], w_rx_bit};
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit_cnt != BIT_LAST) begin
                                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                                r_tx      <= {r_tx[CFG_FRAME_SIZE-2:0], 1'b0};
                            end else begin
                                r_bit_cnt <= '0;
                                // Chained frame starts its low phase immediately: no sck gap.
                                if (w_chain) begin
                                    r_tx   <= tx_data_in;
                                    r_flag <= tx_flag_in;
                                end else begin
                                    r_state <= HOLD;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!w_div_last) begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end else begin
                        r_div_cnt <= '0;
                        r_ssel_n  <= 1'b1;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    if (!w_div_last) begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end else begin
                        r_div_cnt <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
